// File: rtl/fifo_port_arbiter.sv
// Round-robin write-port arbiter and read sequencer in front of an 8x16 FIFO RAM.
// Keeps its own occupancy count and paces every FIFO access to the RAM's two-cycle operation time.
module fifo_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        wr_req,
   input  logic [NUM_REQ*DATA_W-1:0] wr_data,
   output logic [NUM_REQ-1:0]        wr_ack,
   input  logic                      rd_req,
   output logic                      rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      fifo_reset,
   output logic                      fifo_write,
   output logic                      fifo_read,
   output logic [DATA_W-1:0]         fifo_din,
   input  logic [DATA_W-1:0]         fifo_dout,
   output logic [CNT_W-1:0]          count,
   output logic                      full,
   output logic                      empty,
   output logic [2:0]                dbg_state
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_INIT      = 3'd0,
      S_INIT_WAIT = 3'd1,
      S_IDLE      = 3'd2,
      S_WR        = 3'd3,
      S_RD        = 3'd4,
      S_SETTLE    = 3'd5
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   state_t             state, state_d;
   op_t                last_op;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   grant_q;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   scan_idx;
   logic               grant_found;
   logic               flush_pend;
   logic               from_rd;
   logic               wr_elig, rd_elig;
   logic               take_wr, take_rd, clear_pend;

   // Handshake: requesters hold wr_req (and their wr_data) as a level until wr_ack
   // pulses for one cycle, which is the cycle the data is written; the consumer holds
   // rd_req until rd_valid pulses for one cycle with rd_data. Dropping a request
   // before the grant withdraws it.

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign wr_elig   = (|wr_req) && !full;
   assign rd_elig   = rd_req && !empty;
   assign dbg_state = state;

   // First asserted request at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && wr_req[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d    = state;
      take_wr    = 1'b0;
      take_rd    = 1'b0;
      clear_pend = 1'b0;
      case (state)
         S_INIT:      state_d = S_INIT_WAIT;
         S_INIT_WAIT: state_d = S_IDLE;
         S_IDLE: begin
            if (flush_pend) begin
               clear_pend = 1'b1;
               state_d    = S_INIT;
            end else if (wr_elig && rd_elig) begin
               if (last_op == OP_READ) take_wr = 1'b1;
               else                    take_rd = 1'b1;
            end else if (wr_elig) begin
               take_wr = 1'b1;
            end else if (rd_elig) begin
               take_rd = 1'b1;
            end
            if (take_wr) state_d = S_WR;
            if (take_rd) state_d = S_RD;
         end
         S_WR:        state_d = S_SETTLE;
         S_RD:        state_d = S_SETTLE;
         S_SETTLE:    state_d = S_IDLE;
         default:     state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_INIT;
         count      <= '0;
         rr_ptr     <= '0;
         grant_q    <= '0;
         last_op    <= OP_READ;
         flush_pend <= 1'b0;
         from_rd    <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         state   <= state_d;
         from_rd <= (state == S_RD);

         // Cleared while leaving INIT so the count already reads zero in INIT_WAIT.
         if (state == S_INIT)     count <= '0;
         else if (state == S_WR)  count <= count + CNT_W'(1);
         else if (state == S_RD)  count <= count - CNT_W'(1);

         if (take_wr) begin
            grant_q <= grant_idx;
            rr_ptr  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            last_op <= OP_WRITE;
         end
         if (take_rd) last_op <= OP_READ;

         if (clear_pend) flush_pend <= 1'b0;
         else if (flush) flush_pend <= 1'b1;

         rd_valid <= (state == S_SETTLE) && from_rd;
         if ((state == S_SETTLE) && from_rd) rd_data <= fifo_dout;
      end
   end

   // fifo_reset is gated by reset so it stays low while the block itself is held in reset.
   always_comb begin
      fifo_reset = (state == S_INIT) && reset;
      fifo_write = (state == S_WR);
      fifo_read  = (state == S_RD);
      wr_ack     = '0;
      fifo_din   = '0;
      if (state == S_WR) begin
         wr_ack[grant_q] = 1'b1;
         fifo_din        = wr_data[grant_q*DATA_W +: DATA_W];
      end
   end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: behavioural FIFO RAM on the back side,
// expected read data held in a queue, immediate assertions at every check.
module tb_fifo_port_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 16;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 4;

   localparam logic [2:0] ST_INIT      = 3'd0;
   localparam logic [2:0] ST_INIT_WAIT = 3'd1;
   localparam logic [2:0] ST_IDLE      = 3'd2;
   localparam logic [2:0] ST_WR        = 3'd3;
   localparam logic [2:0] ST_RD        = 3'd4;
   localparam logic [2:0] ST_SETTLE    = 3'd5;

   logic                      clk;
   logic                      reset;
   logic                      flush;
   logic [NUM_REQ-1:0]        wr_req;
   logic [NUM_REQ*DATA_W-1:0] wr_data;
   logic [NUM_REQ-1:0]        wr_ack;
   logic                      rd_req;
   logic                      rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic                      fifo_reset;
   logic                      fifo_write;
   logic                      fifo_read;
   logic [DATA_W-1:0]         fifo_din;
   logic [DATA_W-1:0]         fifo_dout = '0;
   logic [CNT_W-1:0]          count;
   logic                      full;
   logic                      empty;
   logic [2:0]                dbg_state;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] fifo_mem[$];

   fifo_port_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .fifo_reset(fifo_reset), .fifo_write(fifo_write), .fifo_read(fifo_read),
      .fifo_din(fifo_din), .fifo_dout(fifo_dout),
      .count(count), .full(full), .empty(empty), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO RAM model: read data lands during the SETTLE cycle after the read strobe
   always @(posedge clk) begin
      if (fifo_reset) begin
         fifo_mem.delete();
      end else if (fifo_write) begin
         fifo_mem.push_back(fifo_din);
      end else if (fifo_read && fifo_mem.size() > 0) begin
         fifo_dout <= fifo_mem.pop_front();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int i, input logic [DATA_W-1:0] d);
      wr_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic check_rd(input string tag);
      logic [DATA_W-1:0] e;
      e = exp_q.pop_front();
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'(e));
   endtask

   // driver: one write from requester i, starting and ending in IDLE
   task automatic do_write(input int i, input logic [DATA_W-1:0] d);
      set_data(i, d);
      wr_req = '0;
      wr_req[i] = 1'b1;
      step();
      chk("w_state", 32'(dbg_state), 32'(ST_WR));
      chk("w_ack", 32'(wr_ack), 32'(1 << i));
      chk("w_din", 32'(fifo_din), 32'(d));
      exp_q.push_back(d);
      wr_req = '0;
      step();
      step();
   endtask

   task automatic do_read();
      rd_req = 1'b1;
      step();
      chk("r_state", 32'(dbg_state), 32'(ST_RD));
      chk("r_strobe", 32'(fifo_read), 32'd1);
      rd_req = 1'b0;
      step();
      step();
      check_rd("r");
   endtask

   initial begin
      reset   = 1'b0;
      flush   = 1'b0;
      wr_req  = '0;
      wr_data = '0;
      rd_req  = 1'b0;

      // 1: reset values, then INIT / INIT_WAIT / IDLE
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fifo_reset", 32'(fifo_reset), 32'd0);
      chk("rst_fifo_write", 32'(fifo_write), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset = 1'b1;
      #1;
      chk("init_state", 32'(dbg_state), 32'(ST_INIT));
      chk("init_fifo_reset", 32'(fifo_reset), 32'd1);
      step();
      chk("iw_state", 32'(dbg_state), 32'(ST_INIT_WAIT));
      chk("iw_fifo_reset", 32'(fifo_reset), 32'd0);
      step();
      chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_full", 32'(full), 32'd0);

      // 2: all four requesters held, grants rotate 0,1,2,3 twice then stop at full
      for (int i = 0; i < NUM_REQ; i++) set_data(i, 16'(16'hA000 + i));
      wr_req = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         step();
         chk("t2_ack", 32'(wr_ack), 32'(1 << (n % 4)));
         chk("t2_din", 32'(fifo_din), 32'(16'hA000 + (n % 4)));
         exp_q.push_back(16'(16'hA000 + (n % 4)));
         step();
         chk("t2_settle_ack", 32'(wr_ack), 32'd0);
         chk("t2_count", 32'(count), 32'(n + 1));
         step();
      end
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_count8", 32'(count), 32'd8);
      repeat (6) begin
         step();
         chk("t2_full_noack", 32'(wr_ack), 32'd0);
      end
      chk("t2_full_idle", 32'(dbg_state), 32'(ST_IDLE));
      wr_req = '0;

      // drain with rd_req held; data returns in write order
      rd_req = 1'b1;
      for (int n = 0; n < 8; n++) begin
         step();
         chk("drain_state", 32'(dbg_state), 32'(ST_RD));
         step();
         step();
         check_rd("drain");
      end
      chk("drain_empty", 32'(empty), 32'd1);
      repeat (4) begin
         step();
         chk("drain_no_valid", 32'(rd_valid), 32'd0);
      end
      rd_req = 1'b0;

      // 3: two writes from requester 2, read back in order, then nothing at empty
      do_write(2, 16'h1111);
      do_write(2, 16'h2222);
      chk("t3_count", 32'(count), 32'd2);
      rd_req = 1'b1;
      for (int n = 0; n < 2; n++) begin
         step();
         step();
         step();
         check_rd("t3");
      end
      chk("t3_empty", 32'(empty), 32'd1);
      repeat (4) begin
         step();
         chk("t3_no_valid", 32'(rd_valid), 32'd0);
         chk("t3_idle", 32'(dbg_state), 32'(ST_IDLE));
      end
      rd_req = 1'b0;

      // 4: count=4 after a read, then contending W/R alternate starting with W
      for (int n = 0; n < 5; n++) do_write(n % 4, 16'(16'h4000 + n));
      do_read();
      chk("t4_count_start", 32'(count), 32'd4);
      set_data(1, 16'h5151);
      wr_req = 4'b0010;
      rd_req = 1'b1;
      for (int op = 0; op < 4; op++) begin
         step();
         if (op % 2 == 0) begin
            chk("t4_op_wr", 32'(dbg_state), 32'(ST_WR));
            chk("t4_ack", 32'(wr_ack), 32'b0010);
            exp_q.push_back(16'h5151);
         end else begin
            chk("t4_op_rd", 32'(dbg_state), 32'(ST_RD));
         end
         step();
         step();
         chk("t4_count", 32'(count), (op % 2 == 0) ? 32'd5 : 32'd4);
         if (op % 2 == 1) check_rd("t4");
      end
      wr_req = '0;
      rd_req = 1'b0;

      // 5: flush during WR at count=5; WR completes, re-init, held request waits for IDLE
      do_write(3, 16'h6363);
      chk("t5_count5", 32'(count), 32'd5);
      set_data(0, 16'h7070);
      wr_req = 4'b0001;
      step();
      chk("t5_wr", 32'(dbg_state), 32'(ST_WR));
      chk("t5_ack", 32'(wr_ack), 32'b0001);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t5_settle", 32'(dbg_state), 32'(ST_SETTLE));
      chk("t5_count6", 32'(count), 32'd6);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t5_idle", 32'(dbg_state), 32'(ST_IDLE));
      step();
      chk("t5_init", 32'(dbg_state), 32'(ST_INIT));
      chk("t5_fifo_reset", 32'(fifo_reset), 32'd1);
      chk("t5_init_ack", 32'(wr_ack), 32'd0);
      step();
      chk("t5_iw", 32'(dbg_state), 32'(ST_INIT_WAIT));
      chk("t5_iw_count", 32'(count), 32'd0);
      chk("t5_iw_ack", 32'(wr_ack), 32'd0);
      step();
      chk("t5_idle2", 32'(dbg_state), 32'(ST_IDLE));
      chk("t5_idle2_ack", 32'(wr_ack), 32'd0);
      chk("t5_empty", 32'(empty), 32'd1);
      exp_q.delete();
      step();
      chk("t5_wr2", 32'(dbg_state), 32'(ST_WR));
      chk("t5_wr2_ack", 32'(wr_ack), 32'b0001);
      exp_q.push_back(16'h7070);
      wr_req = '0;
      step();
      step();
      chk("t5_count1", 32'(count), 32'd1);

      // 6: reset during RD's SETTLE loses rd_valid; INIT sequence reruns
      rd_req = 1'b1;
      step();
      chk("t6_rd", 32'(dbg_state), 32'(ST_RD));
      rd_req = 1'b0;
      step();
      chk("t6_settle", 32'(dbg_state), 32'(ST_SETTLE));
      reset = 1'b0;
      #1;
      chk("t6_state", 32'(dbg_state), 32'(ST_INIT));
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_fifo_read", 32'(fifo_read), 32'd0);
      chk("t6_fifo_reset", 32'(fifo_reset), 32'd0);
      chk("t6_rd_data", 32'(rd_data), 32'd0);
      step();
      chk("t6_no_valid", 32'(rd_valid), 32'd0);
      reset = 1'b1;
      #1;
      chk("t6_init_pulse", 32'(fifo_reset), 32'd1);
      step();
      chk("t6_iw", 32'(dbg_state), 32'(ST_INIT_WAIT));
      chk("t6_iw_valid", 32'(rd_valid), 32'd0);
      step();
      chk("t6_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("t6_empty", 32'(empty), 32'd1);
      exp_q.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
